// File: rtl/useq_loader.sv
// Program RAM and boot loader for the 8-bit microsequencer: clears the 256x8 RAM,
// loads it from a framed, checksummed byte stream and holds the core in reset until an image is valid.
module useq_loader #(
    parameter int         TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0] SYNC_BYTE      = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready,
    input  logic [7:0] mem_addr,
    output logic [7:0] mem_data,
    output logic       core_rst_n,
    output logic       load_busy,
    output logic       load_done,
    output logic       load_err
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_RUN
    } state_t;

    state_t           state;
    logic [7:0]       clr_addr;
    logic [7:0]       wptr;
    logic [7:0]       sum;
    logic [8:0]       count;
    logic [TMO_W-1:0] tmo;
    logic [7:0]       mem [256];

    logic             accept;
    logic             in_frame;
    logic             tmo_hit;
    logic             we;
    logic [7:0]       waddr;
    logic [7:0]       wdata;

    assign accept   = rx_valid && rx_ready;
    assign in_frame = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
    // An accepted byte always wins over an expiring timeout in the same cycle.
    assign tmo_hit  = in_frame && !accept && (tmo == TMO_LAST);

    always_comb begin
        we    = 1'b0;
        waddr = clr_addr;
        wdata = 8'h00;
        if (rst_n) begin
            if (state == S_CLEAR) begin
                we = 1'b1;
            end else if (state == S_DATA && accept) begin
                we    = 1'b1;
                waddr = wptr;
                wdata = rx_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Asynchronous read: a same-cycle write is seen by the core only on the next cycle.
    assign mem_data = mem[mem_addr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_CLEAR;
            clr_addr   <= 8'h00;
            wptr       <= 8'h00;
            sum        <= 8'h00;
            count      <= 9'd0;
            tmo        <= '0;
            rx_ready   <= 1'b0;
            core_rst_n <= 1'b0;
            load_busy  <= 1'b1;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            if (in_frame) begin
                tmo <= accept ? '0 : tmo + 1'b1;
            end

            case (state)
                S_CLEAR: begin
                    clr_addr <= clr_addr + 8'd1;
                    if (clr_addr == 8'hFF) begin
                        state     <= S_IDLE;
                        rx_ready  <= 1'b1;
                        load_busy <= 1'b0;
                    end
                end
                S_IDLE, S_RUN: begin
                    if (accept && rx_data == SYNC_BYTE) begin
                        state      <= S_LEN;
                        load_busy  <= 1'b1;
                        load_done  <= 1'b0;
                        load_err   <= 1'b0;
                        core_rst_n <= 1'b0;
                        wptr       <= 8'h00;
                        sum        <= 8'h00;
                        tmo        <= '0;
                    end
                end
                S_LEN: begin
                    if (accept) begin
                        count <= (rx_data == 8'h00) ? 9'd256 : {1'b0, rx_data};
                        state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        wptr  <= wptr + 8'd1;
                        sum   <= sum + rx_data;
                        count <= count - 9'd1;
                        if (count == 9'd1) begin
                            state <= S_CSUM;
                        end
                    end
                end
                S_CSUM: begin
                    if (accept) begin
                        load_busy <= 1'b0;
                        if (rx_data == sum) begin
                            state      <= S_RUN;
                            load_done  <= 1'b1;
                            core_rst_n <= 1'b1;
                        end else begin
                            state    <= S_IDLE;
                            load_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_CLEAR;
                end
            endcase

            if (tmo_hit) begin
                state     <= S_IDLE;
                load_busy <= 1'b0;
                load_err  <= 1'b1;
                tmo       <= '0;
            end
        end
    end

endmodule

// File: tb/tb_useq_loader.sv
// Directed self-checking bench for useq_loader: clear phase, good/bad frames,
// full 256-byte image, restart from RUN, inter-byte timeout and mid-frame reset.
`timescale 1ns/1ps
module tb_useq_loader;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] mem_addr;
    logic [7:0] mem_data;
    logic       core_rst_n;
    logic       load_busy;
    logic       load_done;
    logic       load_err;

    int n_chk  = 0;
    int n_fail = 0;

    useq_loader #(
        .TIMEOUT_CYCLES(16),
        .SYNC_BYTE     (8'hA5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .core_rst_n(core_rst_n),
        .load_busy (load_busy),
        .load_done (load_done),
        .load_err  (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one byte for exactly one clock edge; returns 1ns after that edge.
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        chk("rx_ready", {31'd0, rx_ready}, 32'd1);
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [7:0] a, input logic [7:0] exp);
        mem_addr = a;
        #1;
        chk(tag, {24'd0, mem_data}, {24'd0, exp});
    endtask

    // Releases reset (rx_valid held high with a sync byte) and checks the clear phase.
    task automatic run_clear();
        int bad;
        bad = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 256; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (rx_ready !== (k == 256)) bad++;
        end
        rx_valid = 1'b0;
        chk("clear_rdy_timing", bad, 0);
        chk("clear_core_rst", {31'd0, core_rst_n}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("clear_no_consume", {31'd0, load_busy}, 32'd0);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            mem_addr = 8'(i);
            #1;
            if (mem_data !== 8'h00) bad++;
        end
        chk("clear_mem_zero", bad, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int bad;
        rst_n    = 1'b0;
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        mem_addr = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rx_ready", {31'd0, rx_ready},   32'd0);
        chk("rst_core",     {31'd0, core_rst_n}, 32'd0);
        chk("rst_busy",     {31'd0, load_busy},  32'd1);
        chk("rst_done",     {31'd0, load_done},  32'd0);
        chk("rst_err",      {31'd0, load_err},   32'd0);
        run_clear();

        // Bad checksum: 10+20 = 30, sent 31
        send(8'hA5); send(8'h02); send(8'h10); send(8'h20); send(8'h31);
        chk("bad_err",  {31'd0, load_err},   32'd1);
        chk("bad_done", {31'd0, load_done},  32'd0);
        chk("bad_idle", {31'd0, load_busy},  32'd0);
        chk("bad_core", {31'd0, core_rst_n}, 32'd0);
        rd("bad_mem0", 8'd0, 8'h10);
        rd("bad_mem1", 8'd1, 8'h20);
        rd("bad_mem2", 8'd2, 8'h00);

        // Good frame
        send(8'hA5);
        chk("a_err_clr", {31'd0, load_err},  32'd0);
        chk("a_busy",    {31'd0, load_busy}, 32'd1);
        send(8'h03); send(8'h11); send(8'h22); send(8'h33);
        chk("a_core_pre", {31'd0, core_rst_n}, 32'd0);
        chk("a_done_pre", {31'd0, load_done},  32'd0);
        send(8'h66);
        chk("a_done", {31'd0, load_done},  32'd1);
        chk("a_core", {31'd0, core_rst_n}, 32'd1);
        chk("a_err",  {31'd0, load_err},   32'd0);
        chk("a_busy_off", {31'd0, load_busy}, 32'd0);
        rd("a_mem0", 8'd0, 8'h11);
        rd("a_mem1", 8'd1, 8'h22);
        rd("a_mem2", 8'd2, 8'h33);
        rd("a_mem3", 8'd3, 8'h00);

        // RUN: stray byte ignored, then reload
        send(8'h7E);
        chk("run_stray_core", {31'd0, core_rst_n}, 32'd1);
        chk("run_stray_busy", {31'd0, load_busy},  32'd0);
        send(8'hA5);
        chk("run_sync_core", {31'd0, core_rst_n}, 32'd0);
        chk("run_sync_done", {31'd0, load_done},  32'd0);
        send(8'h01); send(8'h99);
        chk("run_core_mid", {31'd0, core_rst_n}, 32'd0);
        send(8'h99);
        chk("run_core_up", {31'd0, core_rst_n}, 32'd1);
        chk("run_done",    {31'd0, load_done},  32'd1);
        rd("run_mem0", 8'd0, 8'h99);
        rd("run_mem1", 8'd1, 8'h22);

        // Full 256-byte image, checksum 0x80
        send(8'hA5); send(8'h00);
        for (int i = 0; i < 256; i++) send(8'(i));
        chk("full_busy_csum", {31'd0, load_busy}, 32'd1);
        send(8'h80);
        chk("full_done", {31'd0, load_done},  32'd1);
        chk("full_core", {31'd0, core_rst_n}, 32'd1);
        chk("full_err",  {31'd0, load_err},   32'd0);
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            mem_addr = 8'(i);
            #1;
            if (mem_data !== 8'(i)) bad++;
        end
        chk("full_mem", bad, 0);

        // Inter-byte timeout of 16 cycles
        send(8'hA5); send(8'h03); send(8'h11);
        repeat (15) @(posedge clk);
        #1;
        chk("tmo_err_early",  {31'd0, load_err},  32'd0);
        chk("tmo_busy_early", {31'd0, load_busy}, 32'd1);
        @(posedge clk);
        #1;
        chk("tmo_err",  {31'd0, load_err},  32'd1);
        chk("tmo_idle", {31'd0, load_busy}, 32'd0);
        chk("tmo_done", {31'd0, load_done}, 32'd0);
        send(8'h55);
        chk("tmo_stray_busy", {31'd0, load_busy},  32'd0);
        chk("tmo_stray_err",  {31'd0, load_err},   32'd1);
        chk("tmo_core",       {31'd0, core_rst_n}, 32'd0);
        rd("tmo_mem0", 8'd0, 8'h11);
        rd("tmo_mem3", 8'd3, 8'h03);

        // Reset in the middle of a frame
        send(8'hA5); send(8'h02); send(8'h33);
        chk("mid_busy", {31'd0, load_busy}, 32'd1);
        @(negedge clk);
        rst_n    = 1'b0;
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        @(posedge clk);
        #1;
        chk("mid_rst_core",  {31'd0, core_rst_n}, 32'd0);
        chk("mid_rst_ready", {31'd0, rx_ready},   32'd0);
        chk("mid_rst_busy",  {31'd0, load_busy},  32'd1);
        chk("mid_rst_err",   {31'd0, load_err},   32'd0);
        @(posedge clk);
        run_clear();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/useq_loader.md
# useq_loader

Program-memory and boot-loader stage that sits directly upstream of the 8-bit microsequencer core. It owns the sequencer's 256x8 program RAM, fills it from a byte stream (UART/SPI receiver output) using a framed, checksummed protocol, and holds the core in reset until a valid image has been loaded. During normal operation it serves the core's instruction and LDA fetches combinationally from `mem_addr`.

## Interface

- `TIMEOUT_CYCLES`, default 1000000: maximum idle cycles between bytes inside a frame before the frame is aborted.
- `SYNC_BYTE`, default 8'hA5: frame start marker.

- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `rx_data`  in  8  incoming byte.
- `rx_valid`  in  1  `rx_data` valid.
- `rx_ready`  out  1  loader can accept a byte; transfer occurs on posedge when `rx_valid && rx_ready`.
- `mem_addr`  in  8  core fetch address.
- `mem_data`  out  8  `mem[mem_addr]`, combinational (asynchronous read).
- `core_rst_n`  out  1  reset to core; low while no valid image is present or a load is in progress.
- `load_busy`  out  1  high in CLEAR, LEN, DATA, CSUM.
- `load_done`  out  1  last frame passed checksum.
- `load_err`  out  1  last frame failed (checksum or timeout).

## Operation

- Frame: `SYNC_BYTE`, LEN (0 encodes 256), LEN data bytes written to addresses 0..LEN-1, CSUM = 8-bit sum (mod 256) of the data bytes.
- States: CLEAR, IDLE, LEN, DATA, CSUM, RUN.
- CLEAR: entered on reset; writes 8'h00 to addresses 0..255, one per cycle; `rx_ready`=0; exits to IDLE after address 255.
- IDLE: `rx_ready`=1; accepted `SYNC_BYTE` -> LEN, clears `load_done`/`load_err`, sets wptr=0, sum=0; any other byte is consumed and ignored.
- LEN: accepted byte stored as count (0 -> 256, 9-bit counter) -> DATA.
- DATA: each accepted byte writes `mem[wptr]`, wptr+1, sum+=byte, count-1; after last byte -> CSUM.
- CSUM: accepted byte == sum -> RUN, `load_done`=1; else -> IDLE, `load_err`=1.
- RUN: `core_rst_n`=1; non-sync bytes ignored; `SYNC_BYTE` -> LEN (restart load, core reset reasserted).
- Timeout: in LEN/DATA/CSUM, counter reset on every accepted byte and on state entry; reaching `TIMEOUT_CYCLES` -> IDLE, `load_err`=1.
- Locations beyond LEN keep their previous contents (zero after CLEAR).
- Writes and `mem_data` read same address same cycle: read returns old value (core is in reset during writes, so not functionally observed).

## Timing

- Reset values: `rx_ready`=0, `core_rst_n`=0, `load_busy`=1, `load_done`=0, `load_err`=0, state CLEAR, all counters 0.
- CLEAR lasts exactly 256 cycles after `rst_n` is sampled high; `rx_ready` rises on the 257th cycle.
- `rst_n` low at any time, including mid-frame or in RUN: returns to CLEAR, `core_rst_n`=0 on the next edge.
- `core_rst_n` rises on the edge after CSUM acceptance (registered, same edge as `load_done`); falls on the edge accepting `SYNC_BYTE` in RUN.
- At most one byte accepted per cycle; `rx_ready` remains 1 in all states except CLEAR; back-to-back bytes on consecutive cycles are supported.
- `mem_data` has zero-cycle latency from `mem_addr` (the core samples it on the edge after driving the address).
- Sum and wptr wrap modulo 256.

## Test plan

- Reset, `rx_valid`=1 held: `rx_ready`=0 for 256 cycles, no bytes consumed; all 256 `mem_data` reads 00; `core_rst_n`=0.
- Frame A5 03 11 22 33 66: mem[0..2]=11,22,33, mem[3]=00, `load_done`=1, `core_rst_n`=1 one cycle after CSUM.
- Frame A5 02 10 20 31: `load_err`=1, `core_rst_n` stays 0, state IDLE; subsequent good frame succeeds and clears `load_err`.
- Frame A5 00 plus 256 bytes 00..FF, CSUM 80: mem[i]=i for all i, `load_done`=1.
- A5 03 11 then silence for `TIMEOUT_CYCLES` (set to 16): `load_err`=1 at cycle 16, back to IDLE, stray 55 ignored.
- In RUN, send 7E (ignored, core stays up), then A5 01 99 99: `core_rst_n` low from the A5 edge, mem[0]=99, high again after CSUM; `rst_n` pulse mid-frame -> CLEAR, memory zeroed.
